mem_arb: RTL

MEM_ARB -- requirements
Module: mem_arb

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Purpose  : Shared state encoding and default widths for the memory arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int c_RV_DEFAULT = 16;
    localparam int c_PA_DEFAULT = c_RV_DEFAULT;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUS_I = 2'd1,
        BUS_D = 2'd2,
        FAULT = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb
//  Purpose  : Arbitrates fetch and data requests onto one memory bus, with MMU
//             fault handling. Define MEM_ARB_RR_EN for round-robin arbitration.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arb
    import mem_arb_pkg::*;
#(
    parameter int RV = c_RV_DEFAULT,
    parameter int PA = RV
) (
    input  logic                 clk,
    input  logic                 reset_n,
    // fetch port
    input  logic                 i_req,
    input  logic [PA-RV/16-1:0]  i_addr,
    output logic                 i_ack,
    output logic                 i_err,
    output logic [RV-1:0]        i_rdata,
    // data port
    input  logic                 d_rd,
    input  logic                 d_wr,
    input  logic [RV/8-1:0]      d_bsel,
    input  logic [PA-RV/16-1:0]  d_addr,
    input  logic [RV-1:0]        d_wdata,
    output logic                 d_ack,
    output logic                 d_err,
    output logic [RV-1:0]        d_rdata,
    // mmu port
    output logic                 mmu_is_pc,
    output logic                 mmu_is_read,
    output logic                 mmu_is_write,
    input  logic                 mmu_miss_fault,
    input  logic                 mmu_prot_fault,
    output logic                 mmu_fault,
    // bus port
    output logic                 mem_req,
    output logic                 mem_we,
    output logic [RV/8-1:0]      mem_bsel,
    output logic [PA-RV/16-1:0]  mem_addr,
    output logic [RV-1:0]        mem_wdata,
    input  logic                 mem_ready,
    input  logic [RV-1:0]        mem_rdata
);

    state_t r_state;
    state_t w_state_nxt;
    logic   r_sel_d;
    logic   r_sel_wr;
    logic   w_req_i;
    logic   w_req_d;
    logic   w_pick_d;
    logic   w_grant_i;
    logic   w_grant_d;
    logic   w_fault;

`ifdef MEM_ARB_RR_EN
    logic   r_last_d;
`endif

    always_comb begin
        // A requester keeps its inputs up during its ack cycle; mask it so it is not re-granted.
        w_req_i = i_req & ~i_ack;
        w_req_d = (d_rd | d_wr) & ~d_ack;
`ifdef MEM_ARB_RR_EN
        w_pick_d = w_req_d & (~w_req_i | ~r_last_d);
`else
        w_pick_d = w_req_d;
`endif
        w_grant_d   = (r_state == IDLE) & w_pick_d;
        w_grant_i   = (r_state == IDLE) & w_req_i & ~w_pick_d;
        w_fault     = mmu_miss_fault | mmu_prot_fault;

        w_state_nxt  = r_state;
        mmu_is_pc    = 1'b0;
        mmu_is_read  = 1'b0;
        mmu_is_write = 1'b0;

        case (r_state)
            IDLE: begin
                mmu_is_pc    = w_grant_i;
                mmu_is_write = w_grant_d & d_wr;
                mmu_is_read  = w_grant_d & d_rd & ~d_wr;
                if (w_grant_i | w_grant_d) begin
                    if (w_fault)        w_state_nxt = FAULT;
                    else if (w_grant_d) w_state_nxt = BUS_D;
                    else                w_state_nxt = BUS_I;
                end
            end
            BUS_I, BUS_D: begin
                if (mem_ready) w_state_nxt = IDLE;
            end
            FAULT: begin
                mmu_is_pc    = ~r_sel_d;
                mmu_is_write = r_sel_d & r_sel_wr;
                mmu_is_read  = r_sel_d & ~r_sel_wr;
                w_state_nxt  = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_sel_d   <= 1'b0;
            r_sel_wr  <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_bsel  <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            i_rdata   <= '0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            d_rdata   <= '0;
            mmu_fault <= 1'b0;
`ifdef MEM_ARB_RR_EN
            r_last_d  <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nxt;
            i_ack     <= 1'b0;
            i_err     <= 1'b0;
            d_ack     <= 1'b0;
            d_err     <= 1'b0;
            mmu_fault <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_grant_i | w_grant_d) begin
                        r_sel_d  <= w_grant_d;
                        r_sel_wr <= w_grant_d & d_wr;
`ifdef MEM_ARB_RR_EN
                        r_last_d <= w_grant_d;
`endif
                        if (w_fault) begin
                            mmu_fault <= 1'b1;
                        end else begin
                            mem_req   <= 1'b1;
                            mem_we    <= w_grant_d & d_wr;
                            mem_bsel  <= w_grant_d ? d_bsel : '1;
                            mem_addr  <= w_grant_d ? d_addr : i_addr;
                            mem_wdata <= w_grant_d ? d_wdata : '0;
                        end
                    end
                end
                BUS_I, BUS_D: begin
                    if (mem_ready) begin
                        mem_req <= 1'b0;
                        if (r_state == BUS_I) begin
                            i_rdata <= mem_rdata;
                            i_ack   <= 1'b1;
                        end else begin
                            d_rdata <= mem_rdata;
                            d_ack   <= 1'b1;
                        end
                    end
                end
                FAULT: begin
                    if (r_sel_d) begin
                        d_ack <= 1'b1;
                        d_err <= 1'b1;
                    end else begin
                        i_ack <= 1'b1;
                        i_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
